// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the RV32 execute-stage sequencer.
// State encoding is fixed at 3 bits so it can be probed consistently across builds.
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    EXC_RUN      = 3'd0,
    EXC_RESOLVE  = 3'd1,
    EXC_MEM_WAIT = 3'd2,
    EXC_FLUSH    = 3'd3,
    EXC_HALT     = 3'd4
  } exc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int          CNT_W   = 3;

  // x0 is hard-wired to zero, so a write request to it is never issued.
  function automatic logic wb_allowed(input logic req, input logic [4:0] rd);
    return req && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Decode / execute / data-memory / write-back signal bundle around exec_ctrl.
// master is the controller side; slave is the surrounding core (or a bench).
interface exec_ctrl_if;
  logic        dec_vld;
  logic        dec_rdy;
  logic [4:0]  dec_rd;
  logic        dec_is_load;
  logic        dec_is_store;
  logic        ex_en;
  logic        ex_jump_flag;
  logic [31:0] ex_jump_addr;
  logic [31:0] ex_x_rd;
  logic        ex_x_rd_vld;
  logic        ex_error;
  logic [31:0] mem_rddata;
  logic [31:0] pc;
  logic        pc_load;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;
  logic        halt;

  modport master (
    input  dec_vld, dec_rd, dec_is_load, dec_is_store,
    input  ex_jump_flag, ex_jump_addr, ex_x_rd, ex_x_rd_vld, ex_error,
    input  mem_rddata,
    output dec_rdy, ex_en, pc, pc_load, flush,
    output wb_en, wb_addr, wb_data, retire_cnt, halt
  );

  modport slave (
    output dec_vld, dec_rd, dec_is_load, dec_is_store,
    output ex_jump_flag, ex_jump_addr, ex_x_rd, ex_x_rd_vld, ex_error,
    output mem_rddata,
    input  dec_rdy, ex_en, pc, pc_load, flush,
    input  wb_en, wb_addr, wb_data, retire_cnt, halt
  );
endinterface

// File: rtl/exec_ctrl_wait_counter.sv
// Loadable down-counter; done marks the last counted cycle (count == 1).
// Shared by the memory-latency wait and the front-end flush window.
module wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/exec_ctrl.sv
// Single-issue execute-stage sequencer: issues one instruction, resolves
// jump / write-back / memory wait, owns the PC and halts on execute error.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter int          DATA_LAT     = 1,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  exec_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] MEM_CNT   = CNT_W'(DATA_LAT);
  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_CYCLES);

  exc_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        pc_load_q, pc_load_d;
  logic        flush_q, flush_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        halt_q, halt_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        is_store_q, is_store_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;

  wait_counter #(.W(CNT_W)) u_wait_counter (
    .clk      (clk),
    .srst     (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    retire_cnt_d = retire_cnt_q;
    pc_load_d    = 1'b0;
    flush_d      = flush_q;
    wb_en_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    halt_d       = halt_q;
    rd_d         = rd_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    cnt_load     = 1'b0;
    cnt_load_val = MEM_CNT;

    case (state_q)
      EXC_RUN: begin
        if (bus.dec_vld) begin
          rd_d       = bus.dec_rd;
          is_load_d  = bus.dec_is_load;
          is_store_d = bus.dec_is_store;
          state_d    = EXC_RESOLVE;
        end
      end
      EXC_RESOLVE: begin
        if (bus.ex_error) begin
          halt_d  = 1'b1;
          state_d = EXC_HALT;
        end else if (bus.ex_jump_flag) begin
          // Jump-and-link still writes its return address.
          if (wb_allowed(bus.ex_x_rd_vld, rd_q)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = bus.ex_x_rd;
          end
          pc_d         = bus.ex_jump_addr;
          pc_load_d    = 1'b1;
          retire_cnt_d = retire_cnt_q + 32'd1;
          flush_d      = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = FLUSH_CNT;
          state_d      = EXC_FLUSH;
        end else if (is_load_q || is_store_q) begin
          cnt_load     = 1'b1;
          cnt_load_val = MEM_CNT;
          state_d      = EXC_MEM_WAIT;
        end else begin
          if (wb_allowed(bus.ex_x_rd_vld, rd_q)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = bus.ex_x_rd;
          end
          pc_d         = pc_q + PC_STEP;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = EXC_RUN;
        end
      end
      EXC_MEM_WAIT: begin
        if (cnt_done) begin
          if (wb_allowed(is_load_q, rd_q)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = bus.mem_rddata;
          end
          pc_d         = pc_q + PC_STEP;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = EXC_RUN;
        end
      end
      EXC_FLUSH: begin
        if (cnt_done) begin
          flush_d = 1'b0;
          state_d = EXC_RUN;
        end
      end
      EXC_HALT: begin
        halt_d = 1'b1;
      end
      default: begin
        state_d = EXC_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EXC_RUN;
      pc_q         <= PC_RESET;
      retire_cnt_q <= '0;
      pc_load_q    <= 1'b0;
      flush_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      halt_q       <= 1'b0;
      rd_q         <= '0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retire_cnt_q <= retire_cnt_d;
      pc_load_q    <= pc_load_d;
      flush_q      <= flush_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      halt_q       <= halt_d;
      rd_q         <= rd_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
    end
  end

  // The execute register stage captures on the same edge that moves us to RESOLVE.
  assign bus.dec_rdy    = (state_q == EXC_RUN);
  assign bus.ex_en      = (state_q == EXC_RUN) && bus.dec_vld;
  assign bus.pc         = pc_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.flush      = flush_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.retire_cnt = retire_cnt_q;
  assign bus.halt       = halt_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with DATA_LAT=2, FLUSH_CYCLES=2, PC_RESET=0.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_exec_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exec_ctrl_if bus();

  exec_ctrl #(
    .PC_RESET     (32'h0000_0000),
    .DATA_LAT     (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    bus.ex_jump_flag = 1'b0;
    bus.ex_jump_addr = '0;
    bus.ex_x_rd      = '0;
    bus.ex_x_rd_vld  = 1'b0;
    bus.ex_error     = 1'b0;
  endtask

  // Present one instruction for a single RUN cycle; the controller then sits in RESOLVE.
  task automatic issue(input string tag, input logic [4:0] rd, input logic ld, input logic st);
    bus.dec_vld      = 1'b1;
    bus.dec_rd       = rd;
    bus.dec_is_load  = ld;
    bus.dec_is_store = st;
    #1;
    check({tag, "_ex_en"}, 32'(bus.ex_en), 32'd1);
    tick();
    bus.dec_vld = 1'b0;
    #1;
    check({tag, "_ex_en_off"}, 32'(bus.ex_en), 32'd0);
    check({tag, "_rdy_off"}, 32'(bus.dec_rdy), 32'd0);
  endtask

  task automatic report(input string tag);
    $display("txn %s pc=%h retire=%0d wb_en=%0d wb_addr=%0d wb_data=%h halt=%0d",
             tag, bus.pc, bus.retire_cnt, bus.wb_en, bus.wb_addr, bus.wb_data, bus.halt);
  endtask

  initial begin
    bus.dec_vld = 1'b0; bus.dec_rd = '0; bus.dec_is_load = 1'b0; bus.dec_is_store = 1'b0;
    bus.mem_rddata = '0;
    clear_ex();
    tick(); tick();

    // Reset state
    check("rst_pc", bus.pc, 32'h0);
    check("rst_retire", bus.retire_cnt, 32'd0);
    check("rst_halt", 32'(bus.halt), 32'd0);
    check("rst_wb_en", 32'(bus.wb_en), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_pc_load", 32'(bus.pc_load), 32'd0);
    check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_rdy", 32'(bus.dec_rdy), 32'd1);
    check("rst_ex_en", 32'(bus.ex_en), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ex_en", 32'(bus.ex_en), 32'd0);

    // ADDI x5 = 0x10
    issue("addi", 5'd5, 1'b0, 1'b0);
    bus.ex_x_rd = 32'h10; bus.ex_x_rd_vld = 1'b1;
    tick();
    clear_ex();
    check("addi_wb_en", 32'(bus.wb_en), 32'd1);
    check("addi_wb_addr", 32'(bus.wb_addr), 32'd5);
    check("addi_wb_data", bus.wb_data, 32'h10);
    check("addi_pc", bus.pc, 32'h4);
    check("addi_retire", bus.retire_cnt, 32'd1);
    check("addi_rdy", 32'(bus.dec_rdy), 32'd1);
    report("addi");
    tick();
    check("addi_wb_pulse", 32'(bus.wb_en), 32'd0);
    check("addi_wb_hold", 32'(bus.wb_addr), 32'd5);

    // JAL x1, target 0x100
    issue("jal", 5'd1, 1'b0, 1'b0);
    bus.ex_jump_flag = 1'b1; bus.ex_jump_addr = 32'h100;
    bus.ex_x_rd = 32'h4; bus.ex_x_rd_vld = 1'b1;
    tick();
    clear_ex();
    check("jal_pc", bus.pc, 32'h100);
    check("jal_pc_load", 32'(bus.pc_load), 32'd1);
    check("jal_wb_en", 32'(bus.wb_en), 32'd1);
    check("jal_wb_addr", 32'(bus.wb_addr), 32'd1);
    check("jal_wb_data", bus.wb_data, 32'h4);
    check("jal_retire", bus.retire_cnt, 32'd2);
    check("jal_flush1", 32'(bus.flush), 32'd1);
    check("jal_rdy1", 32'(bus.dec_rdy), 32'd0);
    report("jal");
    bus.dec_vld = 1'b1;
    #1;
    check("jal_ignore_vld1", 32'(bus.ex_en), 32'd0);
    tick();
    check("jal_flush2", 32'(bus.flush), 32'd1);
    check("jal_pc_load_pulse", 32'(bus.pc_load), 32'd0);
    check("jal_rdy2", 32'(bus.dec_rdy), 32'd0);
    check("jal_ignore_vld2", 32'(bus.ex_en), 32'd0);
    bus.dec_vld = 1'b0;
    tick();
    check("jal_flush_end", 32'(bus.flush), 32'd0);
    check("jal_rdy_back", 32'(bus.dec_rdy), 32'd1);
    check("jal_pc_keep", bus.pc, 32'h100);

    // LW x7, two-cycle data latency; stale data in the first wait cycle must not be used
    issue("lw", 5'd7, 1'b1, 1'b0);
    tick();
    check("lw_wait_wb_en", 32'(bus.wb_en), 32'd0);
    check("lw_wait_pc", bus.pc, 32'h100);
    check("lw_wait_rdy", 32'(bus.dec_rdy), 32'd0);
    bus.mem_rddata = 32'h0000_1234;
    tick();
    check("lw_wait2_wb_en", 32'(bus.wb_en), 32'd0);
    bus.mem_rddata = 32'hDEAD_BEEF;
    tick();
    check("lw_wb_en", 32'(bus.wb_en), 32'd1);
    check("lw_wb_addr", 32'(bus.wb_addr), 32'd7);
    check("lw_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    check("lw_pc", bus.pc, 32'h104);
    check("lw_retire", bus.retire_cnt, 32'd3);
    check("lw_rdy", 32'(bus.dec_rdy), 32'd1);
    report("lw");

    // SW never writes back
    issue("sw", 5'd9, 1'b0, 1'b1);
    bus.mem_rddata = 32'h5555_AAAA;
    tick(); tick(); tick();
    check("sw_wb_en", 32'(bus.wb_en), 32'd0);
    check("sw_wb_addr_hold", 32'(bus.wb_addr), 32'd7);
    check("sw_pc", bus.pc, 32'h108);
    check("sw_retire", bus.retire_cnt, 32'd4);
    report("sw");

    // ADD to x0 is suppressed but retires
    issue("add_x0", 5'd0, 1'b0, 1'b0);
    bus.ex_x_rd = 32'h55; bus.ex_x_rd_vld = 1'b1;
    tick();
    clear_ex();
    check("x0_wb_en", 32'(bus.wb_en), 32'd0);
    check("x0_wb_data_hold", bus.wb_data, 32'hDEAD_BEEF);
    check("x0_pc", bus.pc, 32'h10C);
    check("x0_retire", bus.retire_cnt, 32'd5);
    report("add_x0");

    // Jump to the top of the address space, then a plain instruction wraps pc to 0
    issue("j_top", 5'd2, 1'b0, 1'b0);
    bus.ex_jump_flag = 1'b1; bus.ex_jump_addr = 32'hFFFF_FFFC;
    tick();
    clear_ex();
    check("jtop_pc", bus.pc, 32'hFFFF_FFFC);
    check("jtop_wb_en", 32'(bus.wb_en), 32'd0);
    report("j_top");
    tick(); tick();
    check("jtop_rdy", 32'(bus.dec_rdy), 32'd1);
    issue("wrap", 5'd3, 1'b0, 1'b0);
    bus.ex_x_rd = 32'h77; bus.ex_x_rd_vld = 1'b1;
    tick();
    clear_ex();
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_retire", bus.retire_cnt, 32'd7);
    check("wrap_wb_addr", 32'(bus.wb_addr), 32'd3);
    report("wrap");

    // Reset in the middle of a load drops it
    issue("lw_rst", 5'd4, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    bus.mem_rddata = 32'hAAAA_0000;
    tick();
    check("mrst_wb_en", 32'(bus.wb_en), 32'd0);
    check("mrst_pc", bus.pc, 32'h0);
    check("mrst_retire", bus.retire_cnt, 32'd0);
    check("mrst_rdy", 32'(bus.dec_rdy), 32'd1);
    rst = 1'b0;
    tick();
    tick();
    check("mrst_dropped_wb", 32'(bus.wb_en), 32'd0);
    check("mrst_wb_addr", 32'(bus.wb_addr), 32'd0);
    check("mrst_pc_keep", bus.pc, 32'h0);
    report("lw_rst");

    // Execute error halts, sticky until reset
    issue("err", 5'd6, 1'b0, 1'b0);
    bus.ex_error = 1'b1; bus.ex_x_rd = 32'h99; bus.ex_x_rd_vld = 1'b1;
    tick();
    clear_ex();
    check("err_halt", 32'(bus.halt), 32'd1);
    check("err_wb_en", 32'(bus.wb_en), 32'd0);
    check("err_pc", bus.pc, 32'h0);
    check("err_retire", bus.retire_cnt, 32'd0);
    report("err");
    bus.dec_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halt_no_ex_en", 32'(bus.ex_en), 32'd0);
      check("halt_sticky", 32'(bus.halt), 32'd1);
      tick();
    end
    bus.dec_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hrst_halt", 32'(bus.halt), 32'd0);
    check("hrst_pc", bus.pc, 32'h0);
    check("hrst_rdy", 32'(bus.dec_rdy), 32'd1);
    report("halt_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
